// File: rtl/line_buf_ctrl.sv
// Sequencer for a cascaded 3-row line buffer built from two external 1-cycle-latency line RAMs.
// RAM A holds row r-1 and RAM B holds row r-2. One vertical 3-pixel column is emitted per accepted pixel.
module line_buf_ctrl #(
   parameter int WIDTH     = 640,
   parameter int HEIGHT    = 480,
   parameter int ADDR_BITS = 10,
   parameter int ROW_BITS  = 9
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 in_valid_i,
   input  logic                 in_sof_i,
   input  logic [7:0]           in_data_i,
   output logic                 ram_we_o,
   output logic [ADDR_BITS-1:0] ram_waddr_o,
   output logic [7:0]           ram_a_wdata_o,
   output logic [7:0]           ram_b_wdata_o,
   output logic [ADDR_BITS-1:0] ram_raddr_o,
   input  logic [7:0]           ram_a_rdata_i,
   input  logic [7:0]           ram_b_rdata_i,
   output logic                 win_valid_o,
   output logic [7:0]           win_top_o,
   output logic [7:0]           win_mid_o,
   output logic [7:0]           win_bot_o,
   output logic [ADDR_BITS-1:0] win_col_o,
   output logic [ROW_BITS-1:0]  win_row_o,
   output logic                 frame_done_o,
   output logic                 busy_o,
   output logic                 err_unsync_o
);

   localparam logic [ADDR_BITS-1:0] LAST_COL  = ADDR_BITS'(WIDTH - 1);
   localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(HEIGHT - 1);
   localparam logic [ROW_BITS-1:0]  ROW_ONE   = ROW_BITS'(1);
   localparam logic [ROW_BITS-1:0]  FIRST_WIN = ROW_BITS'(2);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_STREAM,
      ST_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] col_q, col_d;
   logic [ROW_BITS-1:0]  row_q, row_d;
   logic [ADDR_BITS-1:0] raddr_q, raddr_d;
   logic                 err_q, err_d;

   logic                 s1_valid_q;
   logic [7:0]           s1_pix_q;
   logic [ADDR_BITS-1:0] s1_col_q;
   logic [ROW_BITS-1:0]  s1_row_q;

   logic                 win_valid_q;
   logic [7:0]           win_top_q, win_mid_q, win_bot_q;
   logic [ADDR_BITS-1:0] win_col_q;
   logic [ROW_BITS-1:0]  win_row_q;
   logic                 frame_done_q;

   logic                 in_frame;
   logic                 sof_px;
   logic                 accept;
   logic [ADDR_BITS-1:0] acc_col;
   logic [ROW_BITS-1:0]  acc_row;
   logic                 acc_last_col;

   // A start-of-frame pixel is always (0,0), regardless of where the counters were.
   always_comb begin
      in_frame     = (state_q == ST_FILL) || (state_q == ST_STREAM);
      sof_px       = in_valid_i && in_sof_i;
      accept       = sof_px || (in_valid_i && in_frame);
      acc_col      = sof_px ? '0 : col_q;
      acc_row      = sof_px ? '0 : row_q;
      acc_last_col = (acc_col == LAST_COL);
   end

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      raddr_d = raddr_q;
      if (accept) begin
         raddr_d = acc_col;
         if (acc_last_col) begin
            col_d = '0;
            row_d = (acc_row == LAST_ROW) ? '0 : acc_row + ROW_ONE;
         end else begin
            col_d = acc_col + ADDR_BITS'(1);
            row_d = acc_row;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      if (sof_px) begin
         state_d = ST_FILL;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid_i) err_d = 1'b1;
            end
            ST_FILL: begin
               if (accept && acc_last_col && (acc_row == ROW_ONE)) state_d = ST_STREAM;
            end
            ST_STREAM: begin
               if (accept && acc_last_col && (acc_row == LAST_ROW)) state_d = ST_DONE;
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         raddr_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         raddr_q <= raddr_d;
         err_q   <= err_d;
      end
   end

   // Stage 1: the accepted pixel waits here while its RAM read completes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_pix_q   <= '0;
         s1_col_q   <= '0;
         s1_row_q   <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_pix_q <= in_data_i;
            s1_col_q <= acc_col;
            s1_row_q <= acc_row;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         win_valid_q  <= 1'b0;
         win_top_q    <= '0;
         win_mid_q    <= '0;
         win_bot_q    <= '0;
         win_col_q    <= '0;
         win_row_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         win_valid_q  <= s1_valid_q && (s1_row_q >= FIRST_WIN);
         frame_done_q <= s1_valid_q && (s1_row_q == LAST_ROW) && (s1_col_q == LAST_COL);
         if (s1_valid_q) begin
            win_top_q <= ram_b_rdata_i;
            win_mid_q <= ram_a_rdata_i;
            win_bot_q <= s1_pix_q;
            win_col_q <= s1_col_q;
            win_row_q <= s1_row_q - ROW_ONE;
         end
      end
   end

   // Write-back shifts the column down one row: new pixel into A, A's old pixel into B.
   always_comb begin
      ram_we_o      = s1_valid_q;
      ram_waddr_o   = s1_col_q;
      ram_a_wdata_o = s1_pix_q;
      ram_b_wdata_o = s1_valid_q ? ram_a_rdata_i : 8'd0;
      ram_raddr_o   = raddr_d;
      win_valid_o   = win_valid_q;
      win_top_o     = win_top_q;
      win_mid_o     = win_mid_q;
      win_bot_o     = win_bot_q;
      win_col_o     = win_col_q;
      win_row_o     = win_row_q;
      frame_done_o  = frame_done_q;
      busy_o        = in_frame;
      err_unsync_o  = err_q;
   end

endmodule
